// File: rtl/bus_pkg.sv
// Shared definitions for the node bus: frame layout, FSM state encoding and
// the CRC-4 (x^4+x+1) helper that the receiver also uses.
package bus_pkg;

    localparam int FRAME_W      = 72;
    localparam int CRC_LSB      = 0;
    localparam int CRC_FIELD_W  = 4;
    localparam int DATA_LSB     = 4;
    localparam int ADDR_LSB     = 68;
    localparam int ADDR_FIELD_W = 4;
    localparam int BIT_CNT_W    = 7;
    localparam int GAP_W        = 4;

    localparam logic [CRC_FIELD_W-1:0] CRC_POLY = 4'h3;
    localparam logic [BIT_CNT_W-1:0]   LAST_BIT = 7'd71;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } bus_state_e;

    // Serial CRC over {addr, data}, MSB first, init 0.
    function automatic logic [CRC_FIELD_W-1:0] crc4_calc(input logic [FRAME_W-DATA_LSB-1:0] msg);
        logic [CRC_FIELD_W-1:0] crc;
        logic                   fb;
        crc = 4'h0;
        for (int i = FRAME_W - DATA_LSB - 1; i >= 0; i--) begin
            fb  = crc[CRC_FIELD_W-1] ^ msg[i];
            crc = {crc[CRC_FIELD_W-2:0], 1'b0} ^ (fb ? CRC_POLY : 4'h0);
        end
        return crc;
    endfunction

    function automatic logic [CRC_FIELD_W-1:0] frame_crc(input logic [FRAME_W-1:0] f);
        return f[CRC_LSB +: CRC_FIELD_W];
    endfunction

    function automatic logic [ADDR_FIELD_W-1:0] frame_addr(input logic [FRAME_W-1:0] f);
        return f[ADDR_LSB +: ADDR_FIELD_W];
    endfunction

endpackage

// File: rtl/bus_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester found searching upward
// from last+1, wrapping at N_NODES-1 back to 0.
module rr_pick #(
    parameter int N_NODES = 16,
    parameter int IDX_W   = 4
) (
    input  logic [N_NODES-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [IDX_W-1:0]   win_idx,
    output logic               win_valid
);

    logic [IDX_W:0] sum_s;
    logic [IDX_W:0] cand_s;
    logic           hit_s;

    // Walk the N_NODES candidates in priority order; the first hit sticks.
    always_comb begin
        win_idx   = '0;
        win_valid = 1'b0;
        sum_s     = '0;
        cand_s    = '0;
        hit_s     = 1'b0;
        for (int off = 1; off <= N_NODES; off++) begin
            sum_s     = {1'b0, last} + (IDX_W+1)'(off);
            cand_s    = (sum_s >= (IDX_W+1)'(N_NODES)) ? (sum_s - (IDX_W+1)'(N_NODES)) : sum_s;
            hit_s     = req[cand_s[IDX_W-1:0]] & ~win_valid;
            win_idx   = hit_s ? cand_s[IDX_W-1:0] : win_idx;
            win_valid = win_valid | hit_s;
        end
    end

endmodule

// File: rtl/bus_tx_arbiter.sv
// Round-robin arbiter and serializer for the shared single-wire node bus.
// Define BUS_ARB_CRC_CHECK_EN to drop frames whose CRC field does not match.
module bus_tx_arbiter
    import bus_pkg::*;
#(
    parameter int N_NODES    = 16,
    parameter int IDX_W      = 4,
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 64,
    parameter int CRC_W      = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [N_NODES-1:0]             req,
    input  logic [ADDR_W+DATA_W+CRC_W-1:0] frame_in,
    output logic [N_NODES-1:0]             grant,
    output logic [IDX_W-1:0]               grant_idx,
    output logic                           busy,
    output logic                           done,
    output logic                           crc_err,
    output logic                           bus_show
);

    localparam logic [N_NODES-1:0] GRANT_ONE = {{(N_NODES-1){1'b0}}, 1'b1};

    bus_state_e             state_q,     state_d;
    logic [IDX_W-1:0]       last_q,      last_d;
    logic [N_NODES-1:0]     grant_q,     grant_d;
    logic [IDX_W-1:0]       grant_idx_q, grant_idx_d;
    logic                   busy_q,      busy_d;
    logic                   done_q,      done_d;
    logic                   crc_err_q,   crc_err_d;
    logic                   bus_show_q,  bus_show_d;
    logic [FRAME_W-1:0]     shreg_q,     shreg_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q,   bit_cnt_d;
    logic [GAP_W-1:0]       gap_cnt_q,   gap_cnt_d;

    logic [IDX_W-1:0]       win_idx_s;
    logic                   win_valid_s;
    logic                   crc_ok_s;

    rr_pick #(
        .N_NODES (N_NODES),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req       (req),
        .last      (last_q),
        .win_idx   (win_idx_s),
        .win_valid (win_valid_s)
    );

`ifdef BUS_ARB_CRC_CHECK_EN
    assign crc_ok_s = (crc4_calc(frame_in[FRAME_W-1:DATA_LSB]) == frame_crc(frame_in));
`else
    assign crc_ok_s = 1'b1;
`endif

    // Next-state and output logic; bus_show idles low unless a bit is being sent.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        crc_err_d   = 1'b0;
        bus_show_d  = 1'b0;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (win_valid_s) begin
                    state_d     = ST_LOAD;
                    last_d      = win_idx_s;
                    grant_idx_d = win_idx_s;
                    grant_d     = GRANT_ONE << win_idx_s;
                    busy_d      = 1'b1;
                end else begin
                    grant_d     = '0;
                end
            end
            ST_LOAD: begin
                if (crc_ok_s) begin
                    shreg_d    = frame_in;
                    bus_show_d = 1'b1;
                    bit_cnt_d  = '0;
                    state_d    = ST_SEND;
                end else begin
                    // Dropped frame: no start bit, but the gap is still honoured.
                    crc_err_d  = 1'b1;
                    grant_d    = '0;
                    gap_cnt_d  = '0;
                    state_d    = ST_GAP;
                end
            end
            ST_SEND: begin
                bus_show_d = shreg_q[FRAME_W-1];
                shreg_d    = {shreg_q[FRAME_W-2:0], 1'b0};
                if (bit_cnt_q == LAST_BIT) begin
                    grant_d   = '0;
                    done_d    = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                end else begin
                    bit_cnt_d = bit_cnt_q + 7'd1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_CYCLES)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            last_q      <= IDX_W'(N_NODES - 1);
            grant_q     <= '0;
            grant_idx_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            crc_err_q   <= 1'b0;
            bus_show_q  <= 1'b0;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            crc_err_q   <= crc_err_d;
            bus_show_q  <= bus_show_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    assign grant     = grant_q;
    assign grant_idx = grant_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign crc_err   = crc_err_q;
    assign bus_show  = bus_show_q;

endmodule

// File: tb/tb_bus_tx_arbiter.sv
// Self-checking bench for bus_tx_arbiter: hand-written grant table, corner
// sequences, and random requests against a round-robin/serial-frame model.
module tb_bus_tx_arbiter;

    localparam int GAP = 2;
    localparam int PERIOD = 74 + GAP + 1;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] req;
    logic [71:0] frame_in;
    logic [15:0] grant;
    logic [3:0]  grant_idx;
    logic        busy, done, crc_err, bus_show;

    logic [71:0] frames [16];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_m = 15;
    int last_grant_cyc = 0;

    typedef struct {
        logic [15:0] req;
        int          idx;
        logic [3:0]  addr;
        logic [63:0] data;
    } vec_t;
    vec_t tbl [12];

    bus_tx_arbiter #(.GAP_CYCLES(GAP)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .frame_in  (frame_in),
        .grant     (grant),
        .grant_idx (grant_idx),
        .busy      (busy),
        .done      (done),
        .crc_err   (crc_err),
        .bus_show  (bus_show)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    assign frame_in = frames[grant_idx];

    // Reference CRC by polynomial long division of msg*x^4 by x^4+x+1.
    function automatic logic [3:0] crc_ref(input logic [67:0] msg);
        logic [71:0] r;
        r = {msg, 4'b0000};
        for (int i = 71; i >= 4; i--)
            if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        return r[3:0];
    endfunction

    function automatic logic [71:0] mk_frame(input logic [3:0] a, input logic [63:0] d);
        return {a, d, crc_ref({a, d})};
    endfunction

    // Round robin: rotate the request word so last+1 sits at bit 0, take lowest set bit.
    function automatic int pick(input logic [15:0] r, input int last);
        logic [31:0] dbl;
        logic [15:0] rot;
        int sh;
        if (r == 16'h0000) return -1;
        sh  = (last + 1) % 16;
        dbl = {r, r} >> sh;
        rot = dbl[15:0];
        for (int j = 0; j < 16; j++)
            if (rot[j]) return (last + 1 + j) % 16;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clock);
            if (grant != 16'h0000) ok = 1'b1;
        end
        chk("grant_seen", 72'(ok), 72'(1));
    endtask

    // One complete frame: grant, start bit, 72 bits MSB first, done, gap, idle.
    task automatic check_frame(input int exp_idx, input int drop_bit, input logic [15:0] drop_req,
                               input int exp_period);
        bit ok;
        logic [71:0] f;
        wait_grant(ok);
        if (!ok) return;
        if (exp_period > 0) chk("frame_period", 72'(cyc - last_grant_cyc), 72'(exp_period));
        last_grant_cyc = cyc;
        chk("grant_onehot", grant, 16'h0001 << exp_idx);
        chk("grant_idx", grant_idx, exp_idx);
        chk("busy_on_grant", busy, 1'b1);
        f = frames[exp_idx];
        @(negedge clock);
        chk("start_bit", bus_show, 1'b1);
        for (int i = 0; i < 72; i++) begin
            @(negedge clock);
            if (i == drop_bit) req = drop_req;
            chk($sformatf("node%0d_bit%0d", exp_idx, i), bus_show, f[71-i]);
            chk($sformatf("done_at_bit%0d", i), done, (i == 71));
        end
        chk("grant_cleared", grant, 16'h0000);
        chk("crc_err_quiet", crc_err, 1'b0);
        for (int g = 0; g < GAP; g++) begin
            @(negedge clock);
            chk("gap_bus_low", bus_show, 1'b0);
            chk("gap_busy", busy, 1'b1);
            chk("gap_done_low", done, 1'b0);
        end
        @(negedge clock);
        chk("busy_dropped", busy, 1'b0);
        chk("idle_bus_low", bus_show, 1'b0);
    endtask

    task automatic check_idle(input int n);
        repeat (n) @(negedge clock);
        chk("idle_grant", grant, 16'h0000);
        chk("idle_busy", busy, 1'b0);
        chk("idle_bus", bus_show, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        int n, other, exp;
        bit prev_frame;
        logic [15:0] r;
        logic [71:0] good;

        tbl[0]  = '{16'h0001, 0,  4'h2, 64'h0000_0000_0000_0001};
        tbl[1]  = '{16'h8001, 15, 4'hA, 64'hDEAD_BEEF_0123_4567};
        tbl[2]  = '{16'h8001, 0,  4'h3, 64'h8000_0000_0000_0000};
        tbl[3]  = '{16'h8001, 15, 4'hF, 64'hFFFF_0000_FFFF_0000};
        tbl[4]  = '{16'h0006, 1,  4'h1, 64'h5555_AAAA_5555_AAAA};
        tbl[5]  = '{16'h0006, 2,  4'h7, 64'h0123_4567_89AB_CDEF};
        tbl[6]  = '{16'h0006, 1,  4'h0, 64'h0000_0000_0000_0000};
        tbl[7]  = '{16'h0100, 8,  4'h8, 64'hCAFE_F00D_1234_5678};
        tbl[8]  = '{16'h0300, 9,  4'h9, 64'h1111_2222_3333_4444};
        tbl[9]  = '{16'h0300, 8,  4'hC, 64'h7FFF_FFFF_FFFF_FFFE};
        tbl[10] = '{16'h1001, 12, 4'hD, 64'hA5A5_5A5A_A5A5_5A5A};
        tbl[11] = '{16'h1001, 0,  4'h4, 64'h0F0F_F0F0_0F0F_F0F0};

        for (int i = 0; i < 16; i++)
            frames[i] = mk_frame(4'(i), {32'hA5A5_0000 | 32'(i), ~32'(i)});

        reset = 1'b1;
        req   = 16'h0000;
        repeat (3) @(negedge clock);
        chk("rst_grant", grant, 16'h0000);
        chk("rst_grant_idx", grant_idx, 4'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_crc_err", crc_err, 1'b0);
        chk("rst_bus", bus_show, 1'b0);
        reset = 1'b0;
        check_idle(3);

        // Grant table: fixed request patterns with hand-derived winners.
        for (int v = 0; v < 12; v++) begin
            req = tbl[v].req;
            frames[tbl[v].idx] = mk_frame(tbl[v].addr, tbl[v].data);
            check_frame(tbl[v].idx, -1, 16'h0000, (v == 0) ? -1 : PERIOD);
            last_m = tbl[v].idx;
        end
        req = 16'h0000;
        check_idle(5);

        // Request withdrawn at bit 30: the frame still runs to completion.
        req = 16'h0030;
        exp = pick(req, last_m);
        check_frame(exp, 30, 16'h0000, -1);
        last_m = exp;
        check_idle(8);

        // Reset in the middle of a frame, bus line high at the time.
        req = 16'h0020;
        exp = pick(req, last_m);
        frames[exp] = mk_frame(4'h5, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_grant(ok);
        chk("mid_rst_idx", grant_idx, exp);
        repeat (42) @(negedge clock);
        chk("mid_rst_bit40", bus_show, 1'b1);
        chk("mid_rst_busy_before", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("mid_rst_bus", bus_show, 1'b0);
        chk("mid_rst_grant", grant, 16'h0000);
        chk("mid_rst_busy", busy, 1'b0);
        @(negedge clock);
        reset  = 1'b0;
        last_m = 15;

        // All nodes requesting: strict 0..15,0 order at the full frame rate.
        req = 16'hFFFF;
        for (int s = 0; s < 17; s++) begin
            check_frame(s % 16, -1, 16'h0000, (s == 0) ? -1 : PERIOD);
            last_m = s % 16;
        end
        req = 16'h0000;
        check_idle(4);

        // Random request words and payloads against the model.
        prev_frame = 1'b0;
        for (int it = 0; it < 20; it++) begin
            r = 16'($urandom_range(0, 65535));
            if (it % 5 == 4) r = 16'h0000;
            req = r;
            exp = pick(r, last_m);
            if (exp < 0) begin
                check_idle(6);
                prev_frame = 1'b0;
            end else begin
                frames[exp] = mk_frame(4'($urandom_range(0, 15)), {$urandom, $urandom});
                check_frame(exp, -1, 16'h0000, prev_frame ? PERIOD : -1);
                last_m = exp;
                prev_frame = 1'b1;
            end
        end
        req = 16'h0000;
        check_idle(4);

        // Frame carrying a corrupted CRC nibble.
        req   = 16'h0006;
        n     = pick(req, last_m);
        other = (n == 1) ? 2 : 1;
        good  = mk_frame(4'h6, 64'h0000_1111_2222_3333);
        frames[n]     = {good[71:4], good[3:0] ^ 4'hF};
        frames[other] = mk_frame(4'hB, 64'h9876_5432_10FE_DCBA);
`ifdef BUS_ARB_CRC_CHECK_EN
        wait_grant(ok);
        chk("crc_bad_idx", grant_idx, n);
        @(negedge clock);
        chk("crc_err_pulse", crc_err, 1'b1);
        chk("crc_no_start", bus_show, 1'b0);
        chk("crc_grant_clear", grant, 16'h0000);
        @(negedge clock);
        chk("crc_err_single", crc_err, 1'b0);
        chk("crc_bus_low", bus_show, 1'b0);
        last_m = n;
        check_frame(other, -1, 16'h0000, -1);
        last_m = other;
`else
        check_frame(n, -1, 16'h0000, -1);
        last_m = n;
`endif
        req = 16'h0000;
        check_idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
